// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants and types for the sequential multiply/divide unit.
package mdu_pkg;

    // funct3 operation codes of the M extension
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // funct7 value that marks an R-type instruction as an M-extension op
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FINAL = 2'b10
    } state_e;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one iteration of the multiply/divide datapath.
// Multiply: shift-add, acc = {partial product, remaining multiplier bits}.
// Divide: restoring, acc[XLEN-1:0] shifts dividend bits out and quotient bits in.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     rem,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   acc_nxt,
    output logic [XLEN-1:0]     rem_nxt
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] rem_sh_s;
    logic          ge_s;

    // Single shift-add or restore-subtract step
    always_comb begin
        sum_s    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        rem_sh_s = {rem, acc[XLEN-1]};
        ge_s     = (rem_sh_s >= {1'b0, opnd});
        if (is_div) begin
            acc_nxt = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ge_s};
            // The remainder after a successful subtract is below the divisor, so XLEN bits suffice
            if (ge_s) begin
                rem_nxt = XLEN'(rem_sh_s - {1'b0, opnd});
            end else begin
                rem_nxt = rem_sh_s[XLEN-1:0];
            end
        end else begin
            rem_nxt = rem;
            if (acc[0]) begin
                acc_nxt = {sum_s, acc[XLEN-1:1]};
            end else begin
                acc_nxt = {1'b0, acc[2*XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: sequential RV32M/RV64M multiply/divide unit, one bit per cycle,
// with fast paths for divide-by-zero and signed division overflow.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int                 CW         = $clog2(XLEN + 1);
    localparam logic [CW-1:0]      COUNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0]      COUNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0]    ZERO_X     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]    ONES_X     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]    ONE_X      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]    MIN_X      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0]  ONE_2X     = {{(2*XLEN-1){1'b0}}, 1'b1};

    state_e              state_r, state_nxt_s;
    logic [CW-1:0]       count_r;
    logic [2:0]          op_r;
    logic                sign_a_r, neg_r, fast_r;
    logic [XLEN-1:0]     opnd_r, rem_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [2*XLEN-1:0]   acc_nxt_s;
    logic [XLEN-1:0]     rem_nxt_s;
    logic                busy_r, done_r;
    logic [XLEN-1:0]     result_r;

    logic                signed_a_s, signed_b_s, sign_a_s, sign_b_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s;
    logic                div_zero_s, ovf_s, fast_s, accept_s;
    logic [XLEN-1:0]     fast_val_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s, remd_s, res_s;
    logic                busy_nxt_s, done_nxt_s;

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign accept_s = (state_r == IDLE) & start & ~flush;

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_r[2]),
        .acc     (acc_r),
        .rem     (rem_r),
        .opnd    (opnd_r),
        .acc_nxt (acc_nxt_s),
        .rem_nxt (rem_nxt_s)
    );

    // Decode the incoming request: operand signedness, magnitudes and fast-path result
    always_comb begin
        case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            F3_MULHSU: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b0;
            end
            default: begin
                signed_a_s = 1'b0;
                signed_b_s = 1'b0;
            end
        endcase
        sign_a_s = signed_a_s & a[XLEN-1];
        sign_b_s = signed_b_s & b[XLEN-1];
        if (sign_a_s) begin
            mag_a_s = ~a + ONE_X;
        end else begin
            mag_a_s = a;
        end
        if (sign_b_s) begin
            mag_b_s = ~b + ONE_X;
        end else begin
            mag_b_s = b;
        end
        div_zero_s = funct3[2] & (b == ZERO_X);
        ovf_s      = ((funct3 == F3_DIV) | (funct3 == F3_REM)) & (a == MIN_X) & (b == ONES_X);
        fast_s     = div_zero_s | ovf_s;
        // funct3[1] separates REM/REMU from DIV/DIVU
        if (div_zero_s) begin
            fast_val_s = funct3[1] ? a : ONES_X;
        end else if (ovf_s) begin
            fast_val_s = funct3[1] ? ZERO_X : a;
        end else begin
            fast_val_s = ZERO_X;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush aborts any in-flight operation
    always_comb begin
        case (state_r)
            IDLE: begin
                if (start && !flush) begin
                    state_nxt_s = fast_s ? FINAL : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (count_r == COUNT_ONE) begin
                    state_nxt_s = FINAL;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FINAL:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: sign fix, result select and next values of busy/done
    always_comb begin
        if (neg_r) begin
            prod_s = ~acc_r + ONE_2X;
            quot_s = ~acc_r[XLEN-1:0] + ONE_X;
        end else begin
            prod_s = acc_r;
            quot_s = acc_r[XLEN-1:0];
        end
        if (sign_a_r) begin
            remd_s = ~rem_r + ONE_X;
        end else begin
            remd_s = rem_r;
        end
        if (fast_r) begin
            res_s = acc_r[XLEN-1:0];
        end else begin
            case (op_r)
                F3_MUL:                        res_s = prod_s[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU:  res_s = prod_s[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:               res_s = quot_s;
                F3_REM, F3_REMU:               res_s = remd_s;
                default:                       res_s = ZERO_X;
            endcase
        end
        done_nxt_s = (state_r == FINAL) & ~flush;
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Operand latch on accept, then one datapath step per CALC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= 3'b000;
            sign_a_r <= 1'b0;
            neg_r    <= 1'b0;
            fast_r   <= 1'b0;
            opnd_r   <= ZERO_X;
            rem_r    <= ZERO_X;
            acc_r    <= {2{ZERO_X}};
            count_r  <= {CW{1'b0}};
        end else if (accept_s) begin
            op_r     <= funct3;
            sign_a_r <= sign_a_s;
            neg_r    <= sign_a_s ^ sign_b_s;
            fast_r   <= fast_s;
            opnd_r   <= mag_b_s;
            rem_r    <= ZERO_X;
            // Multiplier and dividend both start in the low half; fast path parks its answer there
            acc_r    <= {ZERO_X, (fast_s ? fast_val_s : mag_a_s)};
            count_r  <= COUNT_INIT;
        end else if ((state_r == CALC) && !flush) begin
            acc_r    <= acc_nxt_s;
            rem_r    <= rem_nxt_s;
            count_r  <= count_r - COUNT_ONE;
        end
    end

    // Registered outputs; result only changes alongside a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= ZERO_X;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (done_nxt_s) begin
                result_r <= res_s;
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and randomized checks of mdu_seq against an arithmetic reference model.
module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    logic [31:0] last_res;

    mdu_seq #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model from the RISC-V M-extension definitions
    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          p;
        longint unsigned pu;
        int              sx, sy;
        logic [63:0]     v;
        sx = x;
        sy = y;
        case (f)
            F3_MUL:    begin p = longint'(sx) * longint'(sy); v = p; return v[31:0]; end
            F3_MULH:   begin p = longint'(sx) * longint'(sy); v = p; return v[63:32]; end
            F3_MULHSU: begin p = longint'(sx) * longint'({32'h0, y}); v = p; return v[63:32]; end
            F3_MULHU:  begin pu = {32'h0, x} * {32'h0, y}; v = pu; return v[63:32]; end
            F3_DIV: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return 32'(sx / sy);
            end
            F3_DIVU: return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
            F3_REM: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sx % sy);
            end
            default: return (y == 32'h0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && ((y == 32'h0) ||
               ((f == F3_DIV || f == F3_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pickv();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation from an idle or done cycle and wait for its done pulse.
    // poke > 0 raises start with junk operands for one cycle while busy.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input int poke);
        int          lat, bcnt, exp_lat;
        logic [31:0] exp;
        exp     = ref_mdu(f, x, y);
        exp_lat = is_fast(f, x, y) ? 1 : 33;
        funct3 = f; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
        bcnt = int'(busy);
        lat  = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            bcnt += int'(busy);
            if (poke > 0 && lat == poke) begin
                start = 1'b1; funct3 = 3'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_res"}, result, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bcnt), 32'(exp_lat));
        last_res = exp;
    endtask

    // Start an operation, then abort it with flush or reset in the given CALC cycle
    task automatic abort_op(input string tag, input bit use_reset, input int at_cycle);
        int dcnt;
        funct3 = F3_DIVU; a = $urandom; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (at_cycle - 1) @(posedge clk);
        #1;
        if (use_reset) reset = 1'b1;
        else           flush = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0;
        if (use_reset) last_res = 32'h0;
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_res"}, result, last_res);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            dcnt += int'(done) + int'(busy);
        end
        check({tag, "_quiet"}, 32'(dcnt), 32'h0);
        check({tag, "_hold"}, result, last_res);
    endtask

    logic [2:0]  d_f [12] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_DIV, F3_REM,
                              F3_DIVU, F3_REMU, F3_DIV, F3_REMU, F3_DIV, F3_REM};
    logic [31:0] d_a [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd2, 32'd2, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; a = 32'h0; b = 32'h0;
        last_res = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_res", result, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, issued back to back (each start lands in the previous done cycle)
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("dir%0d", i), d_f[i], d_a[i], d_b[i], 0);
        end

        // done is a single-cycle pulse and the result holds afterwards
        @(posedge clk); #1;
        check("pulse_done", 32'(done), 32'h0);
        check("pulse_busy", 32'(busy), 32'h0);
        check("pulse_hold", result, last_res);

        // start together with flush in IDLE is ignored
        funct3 = F3_MUL; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", 32'(busy), 32'h0);

        // start while busy is ignored
        run_op("busy_poke", F3_MUL, 32'd12345, 32'hFFFF_FF00, 5);
        @(posedge clk); #1;

        abort_op("flush10", 1'b0, 10);
        abort_op("reset20", 1'b1, 20);
        run_op("post_rst", F3_REM, 32'hFFFF_FF9C, 32'd7, 0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pickv(), pickv(), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
